// File: rtl/pipe_adder_pkg.sv
// Shared constants and configuration helpers for the pipelined adder.
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    // Width of the slice each pipeline stage adds.
    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // True when the width splits evenly into a non-zero number of stages.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry segment built from full-adder cells.
module adder_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum_c,
    output logic           co_c
);

    logic [SEG:0] carry;

    assign carry[0] = ci;

    // Ripple chain: carry out of bit i feeds bit i+1.
    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .ci   (carry[i]),
            .s_c  (sum_c[i]),
            .co_c (carry[i+1])
        );
    end

    assign co_c = carry[SEG];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);

    assign s_c  = a ^ b ^ ci;
    assign co_c = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit add split over STAGES registered
// segments with a global valid/ready stall.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned MSB  = WIDTH - 1;

    // Reject configurations that do not split evenly.
    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be >= 1 and divisible by STAGES >= 1");
    end

    // Per-stage registers: valid, carry, operand skew and partial sum.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    // Per-stage inputs and next values.
    logic             v_in    [STAGES];
    logic             c_in    [STAGES];
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] s_in    [STAGES];
    logic [SEG-1:0]   seg_sum [STAGES];
    logic             seg_co  [STAGES];
    logic [WIDTH-1:0] s_nxt   [STAGES];

    logic adv_c;

    // Whole pipe advances unless a presented result is being held back.
    assign adv_c    = !v_q[LAST] || out_ready;
    assign in_ready = adv_c;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage 0 takes the ports; later stages take the previous register.
        if (k == 0) begin : g_head
            assign v_in[k] = in_valid;
            assign c_in[k] = cin;
            assign a_in[k] = a;
            assign b_in[k] = b;
            assign s_in[k] = '0;
        end else begin : g_body
            assign v_in[k] = v_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (a_in[k][k*SEG +: SEG]),
            .b     (b_in[k][k*SEG +: SEG]),
            .ci    (c_in[k]),
            .sum_c (seg_sum[k]),
            .co_c  (seg_co[k])
        );

        // Slices k and above of the incoming partial sum are still zero.
        assign s_nxt[k] = s_in[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
    end

    // Stage registers: cleared on reset, frozen together when stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv_c) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                c_q[k] <= seg_co[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nxt[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow from the operand MSBs that travelled with the item.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv_c) begin
            ovf_q <= (a_in[LAST][MSB] == b_in[LAST][MSB]) &&
                     (s_nxt[LAST][MSB] != a_in[LAST][MSB]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder. Successor to the single-bit combinational adder cells.
- Splits a WIDTH-bit add with carry-in into STAGES registered segments.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Used wherever a wide add must close timing at full clock rate.

## Interface
- WIDTH, default 32: operand and sum width in bits; must be ≥ 1 and divisible by STAGES.
- STAGES, default 4: pipeline stages; each stage adds one SEG = WIDTH/STAGES-bit slice; STAGES ≥ 1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Accept: transfer when in_valid && in_ready. Emit: transfer when out_valid && out_ready.
- Global stall: adv = !out_valid || out_ready; in_ready = adv. When adv = 0, every stage register holds, including valid bits.
- Stage k (0..STAGES-1):
  - adds slice k of a and b (bits k*SEG .. k*SEG+SEG-1) plus the carry registered by stage k-1;
  - stage 0 uses cin.
- Operand skew:
  - upper, not-yet-added slices travel with the pipeline;
  - finished lower sum slices travel forward unchanged.
- Valid bit per stage: v[0] <= in_valid && in_ready; v[k] <= v[k-1] when adv.
- Bubbles are not collapsed; an empty stage still advances only on adv.
- Result:
  - sum = all SEG slices concatenated;
  - cout = final stage carry.
- No arithmetic-mode parameter; the bit pattern is identical for signed and unsigned.
- STAGES = 1: a single registered WIDTH-bit add.

## Timing
- Reset (rst_n low at a clk edge):
  - all valid bits clear;
  - out_valid = 0, sum = 0, cout = 0, ovf = 0;
  - in_ready = 1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight results; no partial result is emitted.
- Latency: an item accepted at edge N presents out_valid at edge N+STAGES, provided adv stays 1 throughout.
- Throughput: one result per cycle with out_ready held high.
- Backpressure:
  - out_valid && !out_ready freezes the whole pipe;
  - sum, cout and ovf stay stable until accepted.
- Accept and emit in the same cycle are legal; occupancy is unchanged.
- Wrap-around: all-ones + 1 gives sum = 0, cout = 1; nothing saturates.

## Configuration
- PIPE_ADDER_OVF_EN defined:
  - port ovf exists;
  - ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  - the MSBs are carried down the pipe so ovf aligns with sum.
- Not defined: no ovf port and no associated registers; all other behaviour is identical.

## Structure
- Package pipe_adder_pkg:
  - default WIDTH and STAGES constants;
  - SEG computation function;
  - elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_seg:
  - combinational SEG-bit ripple add with carry in and carry out;
  - instantiated once per stage via generate;
  - built from the team's existing full-adder cell.

## Test plan
- Reset, then idle: out_valid = 0, sum = 0, in_ready = 1.
- WIDTH 32, STAGES 4:
  - a=0x0000_00FF, b=0x0000_0001, cin=0 → sum=0x0000_0100, cout=0, out_valid exactly 4 cycles after accept.
- Carry across every stage boundary:
  - a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1.
- Back-to-back streaming of 16 random pairs with out_ready=1 → 16 consecutive results in order, matching the reference model, one per cycle.
- Backpressure:
  - out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 once out_valid rises;
  - results hold stable; none lost or duplicated after release.
- With PIPE_ADDER_OVF_EN:
  - a=0x7FFF_FFFF, b=1 → ovf=1;
  - a=0x8000_0000, b=0xFFFF_FFFF → ovf=1, cout=1;
  - rst_n pulled low mid-stream → no stale out_valid afterwards.
